// File: rtl/inst_issuer.sv
// Instruction issuer: buffers host-written instructions in a circular FIFO and
// hands them to Control one at a time, with capture/done handshakes and a watchdog.
module inst_issuer #(
    parameter int INST_WIDTH = 27,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [INST_WIDTH-1:0]         host_inst,
    input  logic                          host_inst_valid,
    output logic                          host_inst_ready,
    input  logic                          run,
    input  logic                          err_clr,
    output logic [INST_WIDTH-1:0]         inst,
    output logic                          inst_valid,
    input  logic                          inst_ack,
    input  logic                          exec_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_WIDTH-1:0]          issued_cnt,
    output logic                          irq_done,
    output logic                          err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EXEC, HALT} state_t;

    state_t                  state, state_nxt;
    logic [INST_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [WD_W-1:0]         watchdog;
    logic                    push, pop, timeout;

    // Ready depends on registered count only, so there is no input-to-ready path.
    assign host_inst_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push            = host_inst_valid && host_inst_ready;
    assign pop             = (state == IDLE) && run && (fifo_count != '0);
    assign timeout         = (state == WAIT_EXEC) && !exec_done &&
                             (watchdog == WD_W'(TIMEOUT - 1));
    assign busy            = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = ISSUE;
            ISSUE:     if (inst_ack) state_nxt = WAIT_EXEC;
            WAIT_EXEC: begin
                if (exec_done)    state_nxt = IDLE;
                else if (timeout) state_nxt = HALT;
            end
            HALT:      if (err_clr) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_inst;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            watchdog   <= '0;
            issued_cnt <= '0;
            irq_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (pop) begin
                inst       <= mem[rd_ptr];
                inst_valid <= 1'b1;
            end else if ((state == ISSUE) && inst_ack) begin
                inst_valid <= 1'b0;
            end

            if ((state == ISSUE) && inst_ack) watchdog <= '0;
            else if (state == WAIT_EXEC)      watchdog <= watchdog + 1'b1;

            if ((state == WAIT_EXEC) && exec_done) issued_cnt <= issued_cnt + 1'b1;

            // FIFO is empty after this edge only if nothing is pushed alongside.
            irq_done <= (state == WAIT_EXEC) && exec_done &&
                        (fifo_count == '0) && !push;

            if (timeout)                         err <= 1'b1;
            else if ((state == HALT) && err_clr) err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_issuer.sv
// Directed bench for inst_issuer: expected issue order lives in a queue that a
// separate monitor pops whenever inst_valid rises.
module tb_inst_issuer;
    localparam int IW = 27;
    localparam int D  = 8;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [IW-1:0] host_inst = '0;
    logic          host_inst_valid = 1'b0;
    logic          host_inst_ready;
    logic          run = 1'b0;
    logic          err_clr = 1'b0;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          inst_ack = 1'b0;
    logic          exec_done = 1'b0;
    logic          busy;
    logic [3:0]    fifo_count;
    logic [CW-1:0] issued_cnt;
    logic          irq_done;
    logic          err;

    inst_issuer #(.INST_WIDTH(IW), .FIFO_DEPTH(D), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .host_inst(host_inst), .host_inst_valid(host_inst_valid),
        .host_inst_ready(host_inst_ready),
        .run(run), .err_clr(err_clr),
        .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
        .exec_done(exec_done), .busy(busy), .fifo_count(fifo_count),
        .issued_cnt(issued_cnt), .irq_done(irq_done), .err(err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    int            irq_cnt = 0;
    logic [IW-1:0] exp_q[$];
    logic          prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new issue is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (irq_done) irq_cnt++;
            if (inst_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", {5'd0, inst}, 32'hFFFF_FFFF);
                end else begin
                    logic [IW-1:0] e;
                    e = exp_q.pop_front();
                    chk("issue_order", {5'd0, inst}, {5'd0, e});
                end
            end
            prev_v = inst_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [IW-1:0] w);
        host_inst = w; host_inst_valid = 1'b1;
        tick();
        host_inst_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!inst_valid && k < 20) begin
            tick();
            k++;
        end
        chk("wait_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic do_ack();
        inst_ack = 1'b1; tick(); inst_ack = 1'b0;
    endtask

    task automatic do_done();
        exec_done = 1'b1; tick(); exec_done = 1'b0;
    endtask

    task automatic issue_one();
        wait_valid(); do_ack(); do_done();
    endtask

    initial begin
        logic [IW-1:0] w;
        // Reset values
        #2;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_ready", {31'd0, host_inst_ready}, 32'd1);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        chk("rst_busy_err_irq", {29'd0, busy, err, irq_done}, 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // Single instruction, latency and completion
        run = 1'b1;
        exp_q.push_back(27'h4A0_1234);
        push(27'h4A0_1234);
        chk("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
        chk("t1_valid_not_yet", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("t1_valid_next_cycle", {31'd0, inst_valid}, 32'd1);
        chk("t1_inst", {5'd0, inst}, {5'd0, 27'h4A0_1234});
        do_ack();
        chk("t1_valid_after_ack", {31'd0, inst_valid}, 32'd0);
        chk("t1_busy_wait", {31'd0, busy}, 32'd1);
        do_done();
        chk("t1_issued", {16'd0, issued_cnt}, 32'd1);
        chk("t1_irq", {31'd0, irq_done}, 32'd1);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_irq_one_cycle", {31'd0, irq_done}, 32'd0);

        // Fill to full with run low; ninth word rejected
        run = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            w = IW'(27'h100_0000 + i);
            exp_q.push_back(w);
            push(w);
        end
        chk("t2_ready_full", {31'd0, host_inst_ready}, 32'd0);
        push(27'h7FF_FFFF);
        chk("t2_count_full", {28'd0, fifo_count}, 32'd8);

        // Drain with a push in WAIT_EXEC and a push coinciding with a pop
        run = 1'b1;
        wait_valid(); do_ack();
        exp_q.push_back(27'h200_0009);
        push(27'h200_0009);
        chk("t3_count_refill", {28'd0, fifo_count}, 32'd8);
        do_done();
        issue_one();
        chk("t3_count_before_pp", {28'd0, fifo_count}, 32'd7);
        exp_q.push_back(27'h300_000A);
        push(27'h300_000A);
        chk("t3_count_push_pop", {28'd0, fifo_count}, 32'd7);
        chk("t3_valid_after_pp", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 8; i++) issue_one();
        chk("t3_issued", {16'd0, issued_cnt}, 32'd11);
        chk("t3_exp_empty", exp_q.size(), 32'd0);
        tick();
        chk("t3_irq_total", irq_cnt, 32'd2);

        // Watchdog timeout, HALT, recovery
        exp_q.push_back(27'h0AA_0001);
        exp_q.push_back(27'h0AA_0002);
        push(27'h0AA_0001);
        push(27'h0AA_0002);
        wait_valid(); do_ack();
        repeat (TO - 1) tick();
        chk("t4_err_not_yet", {31'd0, err}, 32'd0);
        tick();
        chk("t4_err_set", {31'd0, err}, 32'd1);
        chk("t4_busy_halt", {31'd0, busy}, 32'd1);
        exp_q.push_back(27'h0AA_0003);
        push(27'h0AA_0003);
        repeat (3) tick();
        chk("t4_no_issue_halt", {31'd0, inst_valid}, 32'd0);
        chk("t4_push_in_halt", {28'd0, fifo_count}, 32'd2);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_err_clear", {31'd0, err}, 32'd0);
        chk("t4_idle_after_clr", {31'd0, busy}, 32'd0);
        issue_one();
        issue_one();
        chk("t4_issued", {16'd0, issued_cnt}, 32'd13);

        // exec_done on the timeout cycle wins
        exp_q.push_back(27'h055_0005);
        push(27'h055_0005);
        wait_valid(); do_ack();
        repeat (TO - 1) tick();
        do_done();
        chk("t5_no_err", {31'd0, err}, 32'd0);
        chk("t5_issued", {16'd0, issued_cnt}, 32'd14);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_irq_total", irq_cnt, 32'd4);

        // Asynchronous reset during WAIT_EXEC with buffered words
        exp_q.push_back(27'h066_0000);
        push(27'h066_0000);
        wait_valid(); do_ack();
        run = 1'b0;
        push(27'h066_0001);
        push(27'h066_0002);
        push(27'h066_0003);
        chk("t6_count_before", {28'd0, fifo_count}, 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("t6_valid", {31'd0, inst_valid}, 32'd0);
        chk("t6_count", {28'd0, fifo_count}, 32'd0);
        chk("t6_issued", {16'd0, issued_cnt}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ready", {31'd0, host_inst_ready}, 32'd1);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("t6_still_idle", {31'd0, inst_valid | busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
